sfifo_level: RTL
================

SFIFO_LEVEL -- requirements
Module: sfifo_level

Interface
REQ-001 The block SHALL have parameter BW, default 16, data width in bits (>=1).
REQ-002 The block SHALL have parameter LGFLEN, default 3, log2 of entry count (>=2); depth D = 2^LGFLEN.
REQ-003 The block SHALL have parameter AFULL_LVL, default D-1, fill at or above which o_afull asserts (1..D).
REQ-004 The block SHALL have parameter AEMPTY_LVL, default 1, fill at or below which o_aempty asserts (0..D-1).
REQ-005 The block SHALL have parameter OPT_WRITE_ON_FULL, default 0; when 1, a write while full is accepted if a read is accepted in the same cycle.
REQ-006 The block SHALL have port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-007 The block SHALL have port i_reset_n, input, 1, reset, synchronous and active-low.
REQ-008 The block SHALL have port i_wr, input, 1, write request.
REQ-009 The block SHALL have port i_data, input, BW, write data.
REQ-010 The block SHALL have port o_full, output, 1, no free entry.
REQ-011 The block SHALL have port o_afull, output, 1, fill >= AFULL_LVL.
REQ-012 The block SHALL have port o_fill, output, LGFLEN+1, current entry count 0..D.
REQ-013 The block SHALL have port i_rd, input, 1, read/pop request.
REQ-014 The block SHALL have port o_data, output, BW, head-of-FIFO data, valid whenever o_empty is low.
REQ-015 The block SHALL have port o_empty, output, 1, no valid head entry.
REQ-016 The block SHALL have port o_aempty, output, 1, fill <= AEMPTY_LVL.

Function
REQ-017 Write accepted (wr_ok) SHALL be i_wr && (!o_full || (OPT_WRITE_ON_FULL && i_rd)).
REQ-018 Read accepted (rd_ok) SHALL be i_rd && !o_empty; i_rd while empty SHALL have no effect.
REQ-019 Pointers SHALL be LGFLEN+1 bits, increment by 1 on wr_ok/rd_ok, wrap modulo 2^(LGFLEN+1); memory indexed by low LGFLEN bits.
REQ-020 o_fill SHALL be registered: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; never exceeds D.
REQ-021 o_full, o_empty, o_afull, o_aempty SHALL be registered, computed from next-cycle fill, so they are exact in the cycle after the causing event.
REQ-022 Show-ahead: o_data SHALL present the oldest unread entry; data written at edge N SHALL appear on o_data with o_empty low after edge N (write-to-valid latency 1 cycle); no bypass of i_data when empty.
REQ-023 On rd_ok at edge N, o_data SHALL present the next entry after edge N; o_data SHALL be stable while !o_empty && !i_rd.
REQ-024 Simultaneous wr_ok and rd_ok with fill==1 SHALL keep o_empty low and present the new word after the edge.
REQ-025 Simultaneous wr_ok and rd_ok when full (OPT_WRITE_ON_FULL=1) SHALL keep o_full high, fill D, and write into the slot just freed.
REQ-026 Write when full without accepted read SHALL be dropped; memory and pointers unchanged.
REQ-027 o_data while o_empty high SHALL be don't-care.

Reset
REQ-028 On a rising edge with i_reset_n low, pointers and o_fill SHALL be 0, o_empty=1, o_full=0, o_aempty=1, o_afull=(AFULL_LVL==0 ? 1 : 0); memory contents not reset.
REQ-029 Reset SHALL override wr/rd in the same cycle; any FIFO contents at mid-operation reset SHALL be discarded.

Verification (BW=8, LGFLEN=3, AFULL_LVL=6, AEMPTY_LVL=1)
REQ-030 Write 0x11..0x18 on 8 consecutive cycles, no reads -> o_fill 1..8, o_afull from fill 6, o_full after 8th write; 9th write 0x99 dropped, o_fill stays 8.
REQ-031 From full, pop 8 times -> o_data sequence 0x11..0x18, o_empty high after last pop, o_aempty high at fill<=1.
REQ-032 Empty FIFO, single write 0xA5 -> next cycle o_empty=0, o_data=0xA5, o_fill=1; i_rd on empty cycle earlier has no effect.
REQ-033 Fill==1, simultaneous write 0x3C and read -> o_fill stays 1, o_empty stays 0, o_data=0x3C.
REQ-034 OPT_WRITE_ON_FULL=1, full, simultaneous write 0x77 and read -> o_full stays 1, 0x77 emerges as 8th pop after 7 more reads.
REQ-035 Fill 5, drive i_reset_n low one cycle -> o_fill=0, o_empty=1, o_full=0; subsequent write 0x42 reads back 0x42 first.

Source files
------------

// File: rtl/sfifo_level.sv
// sfifo_level: synchronous show-ahead FIFO with registered fill level and
// registered full / almost-full / empty / almost-empty flags.
// Flags are computed from the next-cycle fill so they are exact one cycle
// after the event that changes the level. Memory contents are not reset.
module sfifo_level #(
  parameter int BW                = 16,
  parameter int LGFLEN            = 3,
  parameter int AFULL_LVL         = (1 << LGFLEN) - 1,
  parameter int AEMPTY_LVL        = 1,
  parameter bit OPT_WRITE_ON_FULL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic              o_afull,
  output logic [LGFLEN:0]   o_fill,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  output logic              o_aempty
);

  localparam int D = 1 << LGFLEN;

  localparam logic [LGFLEN:0] ONE      = (LGFLEN+1)'(1);
  localparam logic [LGFLEN:0] FILL_MAX = (LGFLEN+1)'(D);
  localparam logic [LGFLEN:0] AFULL_V  = (LGFLEN+1)'(AFULL_LVL);
  localparam logic [LGFLEN:0] AEMPTY_V = (LGFLEN+1)'(AEMPTY_LVL);

  logic [BW-1:0]   mem_q [D];

  logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0] fill_q,   fill_d;
  logic            full_q,   full_d;
  logic            empty_q,  empty_d;
  logic            afull_q,  afull_d;
  logic            aempty_q, aempty_d;

  logic            wr_ok;
  logic            rd_ok;

  // Accept logic, pointer advance, next fill and next-cycle flags.
  always_comb begin
    rd_ok    = i_rd && !empty_q;
    // A write while full is only legal when the head is popped in the same
    // cycle, in which case it lands in the slot being freed.
    wr_ok    = i_wr && (!full_q || (OPT_WRITE_ON_FULL && i_rd));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end

    case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + ONE;
      2'b01:   fill_d = fill_q - ONE;
      default: fill_d = fill_q;
    endcase

    full_d   = (fill_d == FILL_MAX);
    empty_d  = (fill_d == '0);
    afull_d  = (fill_d >= AFULL_V);
    aempty_d = (fill_d <= AEMPTY_V);
  end

  // Pointer, level and flag registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_LVL == 0);
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage array; written only on an accepted write outside reset.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && wr_ok) begin
      mem_q[wr_ptr_q[LGFLEN-1:0]] <= i_data;
    end
  end

  // Show-ahead head word and registered status outputs.
  always_comb begin
    o_data   = mem_q[rd_ptr_q[LGFLEN-1:0]];
    o_fill   = fill_q;
    o_full   = full_q;
    o_empty  = empty_q;
    o_afull  = afull_q;
    o_aempty = aempty_q;
  end

endmodule
